// File: rtl/editor_dato_display.sv
// BCD time/date editor: six field registers, edit cursor, up/down stepping and an RTC write handshake.
// Optional month-aware day range enabled by defining EDITOR_DIAS_MES_EN.
module editor_dato_display #(
  parameter int N = 8,
  parameter int P = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         f1,
  input  logic         f2,
  input  logic         f3,
  input  logic         carga,
  input  logic         editar,
  input  logic         izq,
  input  logic         der,
  input  logic         sube,
  input  logic         baja,
  input  logic         guardar,
  input  logic         wr_ack,
  input  logic [N-1:0] dato_hora_in,
  input  logic [N-1:0] dato_min_in,
  input  logic [N-1:0] dato_seg_in,
  input  logic [N-1:0] dato_dia_in,
  input  logic [N-1:0] dato_mes_in,
  input  logic [N-1:0] dato_year_in,
  output logic [N-1:0] dato_hora,
  output logic [N-1:0] dato_min,
  output logic [N-1:0] dato_seg,
  output logic [N-1:0] dato_dia,
  output logic [N-1:0] dato_mes,
  output logic [N-1:0] dato_year,
  output logic [P-1:0] posicion,
  output logic         en_edicion,
  output logic         wr_req
);

  typedef enum logic [1:0] {IDLE, EDIT, WRITE} state_t;

  state_t         state_reg, state_next;
  logic           grupo_reg, grupo_next;
  logic [P-1:0]   pos_reg, pos_next;
  logic [N-1:0]   hora_reg, hora_next, min_reg, min_next, seg_reg, seg_next;
  logic [N-1:0]   dia_reg, dia_next, mes_reg, mes_next, year_reg, year_next;
  logic           unused_f2;

  assign unused_f2 = f2;

  // Out-of-range or non-BCD values snap to the field minimum on the first step.
  function automatic logic [N-1:0] bcd_step(input logic [N-1:0] v, input logic [N-1:0] lo,
                                            input logic [N-1:0] hi, input logic up);
    if (v[3:0] > 4'd9 || v[7:4] > 4'd9 || v < lo || v > hi) bcd_step = lo;
    else if (up) begin
      if (v == hi)              bcd_step = lo;
      else if (v[3:0] == 4'd9)  bcd_step = {v[7:4] + 4'd1, 4'd0};
      else                      bcd_step = v + 8'd1;
    end else begin
      if (v == lo)              bcd_step = hi;
      else if (v[3:0] == 4'd0)  bcd_step = {v[7:4] - 4'd1, 4'd9};
      else                      bcd_step = v - 8'd1;
    end
  endfunction

`ifdef EDITOR_DIAS_MES_EN
  // Leap test on the two-digit BCD year: tens parity decides which units are multiples of 4.
  function automatic logic [N-1:0] dias_mes(input logic [N-1:0] m, input logic [N-1:0] y);
    logic leap;
    leap = y[4] ? (y[3:0] == 4'd2 || y[3:0] == 4'd6)
                : (y[3:0] == 4'd0 || y[3:0] == 4'd4 || y[3:0] == 4'd8);
    case (m)
      8'h02:                      dias_mes = leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: dias_mes = 8'h30;
      default:                    dias_mes = 8'h31;
    endcase
  endfunction

  function automatic logic [N-1:0] clamp(input logic [N-1:0] d, input logic [N-1:0] mx);
    clamp = (d > mx) ? mx : d;
  endfunction
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      grupo_reg <= 1'b0;
      pos_reg   <= '0;
      hora_reg  <= 8'h00;
      min_reg   <= 8'h00;
      seg_reg   <= 8'h00;
      dia_reg   <= 8'h01;
      mes_reg   <= 8'h01;
      year_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      grupo_reg <= grupo_next;
      pos_reg   <= pos_next;
      hora_reg  <= hora_next;
      min_reg   <= min_next;
      seg_reg   <= seg_next;
      dia_reg   <= dia_next;
      mes_reg   <= mes_next;
      year_reg  <= year_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grupo_next = grupo_reg;
    pos_next   = pos_reg;
    hora_next  = hora_reg;
    min_next   = min_reg;
    seg_next   = seg_reg;
    dia_next   = dia_reg;
    mes_next   = mes_reg;
    year_next  = year_reg;
    case (state_reg)
      IDLE: begin
        if (editar) begin
          state_next = EDIT;
          grupo_next = f1 | f3;
          pos_next   = '0;
        end else if (carga) begin
          hora_next = dato_hora_in;
          min_next  = dato_min_in;
          seg_next  = dato_seg_in;
          dia_next  = dato_dia_in;
          mes_next  = dato_mes_in;
          year_next = dato_year_in;
        end
      end
      EDIT: begin
        // A forced position 3 behaves like position 0.
        if (der && !izq) begin
          case (pos_reg)
            P'(1):   pos_next = P'(2);
            P'(2):   pos_next = P'(0);
            default: pos_next = P'(1);
          endcase
        end else if (izq && !der) begin
          case (pos_reg)
            P'(1):   pos_next = P'(0);
            P'(2):   pos_next = P'(1);
            default: pos_next = P'(2);
          endcase
        end
        if (sube != baja) begin
          if (grupo_reg) begin
            case (pos_reg)
              P'(1):   min_next  = bcd_step(min_reg, 8'h00, 8'h59, sube);
              P'(2):   seg_next  = bcd_step(seg_reg, 8'h00, 8'h59, sube);
              default: hora_next = bcd_step(hora_reg, 8'h00, 8'h23, sube);
            endcase
          end else begin
            case (pos_reg)
              P'(1): begin
                mes_next = bcd_step(mes_reg, 8'h01, 8'h12, sube);
`ifdef EDITOR_DIAS_MES_EN
                dia_next = clamp(dia_reg, dias_mes(mes_next, year_reg));
`endif
              end
              P'(2): begin
                year_next = bcd_step(year_reg, 8'h00, 8'h99, sube);
`ifdef EDITOR_DIAS_MES_EN
                dia_next  = clamp(dia_reg, dias_mes(mes_reg, year_next));
`endif
              end
              default: begin
`ifdef EDITOR_DIAS_MES_EN
                dia_next = bcd_step(dia_reg, 8'h01, dias_mes(mes_reg, year_reg), sube);
`else
                dia_next = bcd_step(dia_reg, 8'h01, 8'h31, sube);
`endif
              end
            endcase
          end
        end
        if (guardar) state_next = WRITE;
      end
      WRITE: begin
        if (wr_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dato_hora  = hora_reg;
  assign dato_min   = min_reg;
  assign dato_seg   = seg_reg;
  assign dato_dia   = dia_reg;
  assign dato_mes   = mes_reg;
  assign dato_year  = year_reg;
  assign posicion   = pos_reg;
  assign en_edicion = (state_reg == EDIT);
  assign wr_req     = (state_reg == WRITE);

endmodule

// File: tb/tb_editor_dato_display.sv
// Directed bench for editor_dato_display: loading, cursor/field editing, BCD wrap, write handshake, reset.
module tb_editor_dato_display;
  logic clk = 1'b0;
  logic reset;
  logic f1, f2, f3, carga, editar, izq, der, sube, baja, guardar, wr_ack;
  logic [7:0] dato_hora_in, dato_min_in, dato_seg_in, dato_dia_in, dato_mes_in, dato_year_in;
  logic [7:0] dato_hora, dato_min, dato_seg, dato_dia, dato_mes, dato_year;
  logic [1:0] posicion;
  logic en_edicion, wr_req;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  editor_dato_display #(.N(8), .P(2)) dut (
    .clk(clk), .reset(reset), .f1(f1), .f2(f2), .f3(f3), .carga(carga), .editar(editar),
    .izq(izq), .der(der), .sube(sube), .baja(baja), .guardar(guardar), .wr_ack(wr_ack),
    .dato_hora_in(dato_hora_in), .dato_min_in(dato_min_in), .dato_seg_in(dato_seg_in),
    .dato_dia_in(dato_dia_in), .dato_mes_in(dato_mes_in), .dato_year_in(dato_year_in),
    .dato_hora(dato_hora), .dato_min(dato_min), .dato_seg(dato_seg), .dato_dia(dato_dia),
    .dato_mes(dato_mes), .dato_year(dato_year), .posicion(posicion),
    .en_edicion(en_edicion), .wr_req(wr_req)
  );

  // Pulse one or more buttons for a single sampled edge; outputs are settled on return.
  task automatic press(input logic p_carga, input logic p_editar, input logic p_izq, input logic p_der,
                       input logic p_sube, input logic p_baja, input logic p_guardar);
    carga = p_carga; editar = p_editar; izq = p_izq; der = p_der;
    sube = p_sube; baja = p_baja; guardar = p_guardar;
    @(negedge clk);
    carga = 0; editar = 0; izq = 0; der = 0; sube = 0; baja = 0; guardar = 0;
  endtask

  task automatic test_reset;
    n_checks++;
    if ({dato_hora, dato_min, dato_seg, dato_dia, dato_mes, dato_year} !== 48'h00_00_00_01_01_00) begin
      n_fail++;
      $display("FAIL reset_regs: got %h%h%h%h%h%h expected 000000010100",
               dato_hora, dato_min, dato_seg, dato_dia, dato_mes, dato_year);
    end
    n_checks++;
    if ({posicion, en_edicion, wr_req} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got pos=%0d edit=%b req=%b expected 0 0 0", posicion, en_edicion, wr_req);
    end
  endtask

  task automatic test_time_edit;
    dato_hora_in = 8'h23; dato_min_in = 8'h59; dato_seg_in = 8'h58;
    dato_dia_in = 8'h31; dato_mes_in = 8'h12; dato_year_in = 8'h00;
    f1 = 1; f2 = 0; f3 = 0;
    press(1, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if ({dato_hora, dato_min, dato_seg, dato_dia, dato_mes} !== 40'h23_59_58_31_12) begin
      n_fail++;
      $display("FAIL carga: got %h %h %h %h %h expected 23 59 58 31 12",
               dato_hora, dato_min, dato_seg, dato_dia, dato_mes);
    end
    press(0, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if ({en_edicion, posicion} !== 3'b100) begin
      n_fail++;
      $display("FAIL editar: got edit=%b pos=%0d expected 1 0", en_edicion, posicion);
    end
    press(0, 0, 0, 0, 1, 0, 0);
    n_checks++;
    if (dato_hora !== 8'h00) begin n_fail++; $display("FAIL hora_wrap_up: got %h expected 00", dato_hora); end
    press(0, 0, 0, 0, 0, 1, 0);
    n_checks++;
    if (dato_hora !== 8'h23) begin n_fail++; $display("FAIL hora_wrap_down: got %h expected 23", dato_hora); end
    press(0, 0, 0, 1, 0, 0, 0);
    press(0, 0, 0, 1, 0, 0, 0);
    n_checks++;
    if (posicion !== 2'd2) begin n_fail++; $display("FAIL der_x2: got %0d expected 2", posicion); end
    press(0, 0, 0, 0, 1, 0, 0);
    n_checks++;
    if (dato_seg !== 8'h59) begin n_fail++; $display("FAIL seg_inc: got %h expected 59", dato_seg); end
    press(0, 0, 0, 0, 1, 0, 0);
    n_checks++;
    if ({dato_seg, dato_min, dato_hora} !== 24'h00_59_23) begin
      n_fail++;
      $display("FAIL seg_wrap: got seg=%h min=%h hora=%h expected 00 59 23", dato_seg, dato_min, dato_hora);
    end
  endtask

  task automatic test_write;
    int req_cycles;
    press(0, 0, 0, 0, 0, 0, 1);
    n_checks++;
    if ({en_edicion, wr_req} !== 2'b01) begin
      n_fail++;
      $display("FAIL guardar: got edit=%b req=%b expected 0 1", en_edicion, wr_req);
    end
    req_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      if (wr_req === 1'b1) req_cycles++;
      wr_ack = (i == 5);
      sube   = (i == 2);
      @(negedge clk);
    end
    wr_ack = 0; sube = 0;
    n_checks++;
    if (req_cycles != 6) begin n_fail++; $display("FAIL wr_req_len: got %0d cycles expected 6", req_cycles); end
    n_checks++;
    if ({wr_req, en_edicion} !== 2'b00) begin
      n_fail++;
      $display("FAIL write_to_idle: got req=%b edit=%b expected 0 0", wr_req, en_edicion);
    end
    n_checks++;
    if ({dato_hora, dato_seg} !== 16'h23_00) begin
      n_fail++;
      $display("FAIL write_frozen: got hora=%h seg=%h expected 23 00", dato_hora, dato_seg);
    end
  endtask

  task automatic test_date_edit;
    f1 = 0; f2 = 1; f3 = 0;
    press(0, 1, 0, 0, 0, 0, 0);
    f2 = 0; f1 = 1;
    press(0, 0, 1, 0, 0, 0, 0);
    n_checks++;
    if (posicion !== 2'd2) begin n_fail++; $display("FAIL izq_wrap: got %0d expected 2", posicion); end
    press(0, 0, 0, 0, 0, 1, 0);
    n_checks++;
    if ({dato_year, dato_seg} !== 16'h99_00) begin
      n_fail++;
      $display("FAIL year_wrap_down: got year=%h seg=%h expected 99 00", dato_year, dato_seg);
    end
    press(0, 0, 0, 1, 0, 0, 0);
    press(0, 0, 0, 1, 0, 0, 0);
    n_checks++;
    if (posicion !== 2'd1) begin n_fail++; $display("FAIL der_to_mes: got %0d expected 1", posicion); end
    press(0, 0, 0, 0, 1, 0, 0);
    n_checks++;
    if ({dato_mes, dato_dia} !== 16'h01_31) begin
      n_fail++;
      $display("FAIL mes_wrap_up: got mes=%h dia=%h expected 01 31", dato_mes, dato_dia);
    end
    press(0, 0, 0, 0, 1, 0, 0);
    n_checks++;
`ifdef EDITOR_DIAS_MES_EN
    if ({dato_mes, dato_dia} !== 16'h02_28) begin
      n_fail++;
      $display("FAIL feb_clamp: got mes=%h dia=%h expected 02 28", dato_mes, dato_dia);
    end
`else
    if ({dato_mes, dato_dia} !== 16'h02_31) begin
      n_fail++;
      $display("FAIL feb_noclamp: got mes=%h dia=%h expected 02 31", dato_mes, dato_dia);
    end
`endif
    press(0, 0, 0, 0, 1, 1, 0);
    n_checks++;
    if (dato_mes !== 8'h02) begin n_fail++; $display("FAIL sube_baja: got %h expected 02", dato_mes); end
    press(0, 0, 1, 1, 0, 0, 0);
    n_checks++;
    if (posicion !== 2'd1) begin n_fail++; $display("FAIL izq_der: got %0d expected 1", posicion); end
    // Minimum handshake: ack in the first WRITE cycle.
    press(0, 0, 0, 0, 0, 0, 1);
    n_checks++;
    if (wr_req !== 1'b1) begin n_fail++; $display("FAIL min_hs_req: got %b expected 1", wr_req); end
    wr_ack = 1;
    @(negedge clk);
    wr_ack = 0;
    n_checks++;
    if ({wr_req, en_edicion} !== 2'b00) begin
      n_fail++;
      $display("FAIL min_hs_drop: got req=%b edit=%b expected 0 0", wr_req, en_edicion);
    end
  endtask

  task automatic test_editar_carga;
    f1 = 1;
    dato_hora_in = 8'h11; dato_min_in = 8'h22;
    press(1, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if ({en_edicion, dato_hora, dato_min} !== 17'h1_23_59) begin
      n_fail++;
      $display("FAIL editar_carga: got edit=%b hora=%h min=%h expected 1 23 59", en_edicion, dato_hora, dato_min);
    end
    press(1, 0, 0, 0, 0, 0, 0);
    wr_ack = 1;
    @(negedge clk);
    wr_ack = 0;
    n_checks++;
    if ({en_edicion, wr_req, dato_hora} !== 10'b10_0010_0011) begin
      n_fail++;
      $display("FAIL edit_ignores: got edit=%b req=%b hora=%h expected 1 0 23", en_edicion, wr_req, dato_hora);
    end
    press(0, 0, 0, 0, 0, 0, 1);
    wr_ack = 1;
    @(negedge clk);
    wr_ack = 0;
    dato_hora_in = 8'h7A;
    press(1, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (dato_hora !== 8'h7A) begin n_fail++; $display("FAIL carga_invalid: got %h expected 7a", dato_hora); end
    press(0, 1, 0, 0, 0, 0, 0);
    press(0, 0, 0, 0, 1, 0, 0);
    n_checks++;
    if (dato_hora !== 8'h00) begin n_fail++; $display("FAIL invalid_to_min: got %h expected 00", dato_hora); end
  endtask

  task automatic test_reset_mid;
    press(0, 0, 0, 0, 0, 0, 1);
    n_checks++;
    if (wr_req !== 1'b1) begin n_fail++; $display("FAIL pre_reset_req: got %b expected 1", wr_req); end
    #2 reset = 1;
    #1;
    n_checks++;
    if ({wr_req, en_edicion, posicion, dato_hora, dato_min, dato_dia, dato_mes, dato_year} !== 44'h0_00_00_01_01_00) begin
      n_fail++;
      $display("FAIL async_reset: got req=%b edit=%b pos=%0d %h %h %h %h %h expected all reset values",
               wr_req, en_edicion, posicion, dato_hora, dato_min, dato_dia, dato_mes, dato_year);
    end
    @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({wr_req, en_edicion} !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_idle: got req=%b edit=%b expected 0 0", wr_req, en_edicion);
    end
  endtask

  initial begin
    reset = 1;
    f1 = 0; f2 = 0; f3 = 0; carga = 0; editar = 0; izq = 0; der = 0;
    sube = 0; baja = 0; guardar = 0; wr_ack = 0;
    dato_hora_in = 0; dato_min_in = 0; dato_seg_in = 0;
    dato_dia_in = 0; dato_mes_in = 0; dato_year_in = 0;
    repeat (2) @(negedge clk);
    test_reset;
    reset = 0;
    @(negedge clk);
    test_time_edit;
    test_write;
    test_date_edit;
    test_editar_carga;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/editor_dato_display.md
# editor_dato_display

Write-side companion to the display data multiplexer: holds the six BCD time/date registers (hour, minute, second, day, month, year), lets the user move an edit cursor and step the selected field up/down with BCD wrap-around, and hands the edited set to the RTC bus controller through a req/ack handshake. It drives `posicion` and the `dato_*` buses that the display mux consumes. It sits between the debounced push-button pulses and the RTC write path.

## Interface
- `N`, 8: BCD data width (two digits).
- `P`, 2: cursor width.

- `clk` in 1: system clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-high.
- `f1`, `f2`, `f3` in 1 each: function flags. `f1||f3` selects the time group; otherwise the date group.
- `carga` in 1: one-cycle pulse, loads all `*_in` values.
- `editar` in 1: one-cycle pulse, enters edit.
- `izq`, `der` in 1: one-cycle pulses, move the cursor.
- `sube`, `baja` in 1: one-cycle pulses, increment or decrement the selected field.
- `guardar` in 1: one-cycle pulse, leaves edit and requests a write.
- `wr_ack` in 1: write acknowledge from the RTC controller.
- `dato_hora_in`, `dato_min_in`, `dato_seg_in`, `dato_dia_in`, `dato_mes_in`, `dato_year_in` in N: values read back from the RTC.
- `dato_hora`, `dato_min`, `dato_seg`, `dato_dia`, `dato_mes`, `dato_year` out N: current BCD registers.
- `posicion` out P: cursor position, 0..2.
- `en_edicion` out 1: high in EDIT.
- `wr_req` out 1: write request, high in WRITE.

## Operation
- FSM states: IDLE, EDIT, WRITE. Reset puts the FSM in IDLE.
- IDLE:
  - `carga` loads all six registers from `*_in`.
  - `editar` goes to EDIT, latches `grupo = f1||f3`, and clears `posicion` to 0.
  - `editar` wins over `carga` in the same cycle; the load is dropped.
- EDIT:
  - `der`: `posicion` goes 0→1→2→0.
  - `izq`: `posicion` goes 0→2→1→0.
  - `izq` and `der` together: no change.
  - Field selected by `posicion`:
    - time group: 0 hour, 1 minute, 2 second.
    - date group: 0 day, 1 month, 2 year.
    - `posicion` 3 is unreachable; if forced, it is treated as 0.
  - `sube`/`baja` step the selected field by 1 in BCD. `sube` and `baja` together: no change.
  - Ranges, with wrap at both ends:
    - hour 00–23
    - minute and second 00–59
    - day 01–31
    - month 01–12
    - year 00–99
  - Invalid BCD loaded via `carga` (e.g. 8'h7A) is replaced by the field minimum on the first `sube` or `baja`.
  - `guardar` goes to WRITE. A `sube`/`baja` in the same cycle is applied first.
  - `carga` and `editar` are ignored.
- WRITE:
  - `wr_req`=1 and the registers are frozen.
  - All button pulses and `carga` are ignored.
  - When `wr_ack` is sampled high, the FSM returns to IDLE.
- `wr_ack` outside WRITE is ignored.
- Group flags changing during EDIT have no effect until the next `editar`.

## Timing
- Reset values:
  - `dato_hora`, `dato_min`, `dato_seg`, `dato_year` = 8'h00.
  - `dato_dia`, `dato_mes` = 8'h01.
  - `posicion` = 0, `en_edicion` = 0, `wr_req` = 0.
- Latency: every register and output change is visible on the edge after the cycle the pulse is sampled (1 cycle).
- `en_edicion` rises 1 cycle after `editar` and falls 1 cycle after `guardar`.
- `wr_req` rises in the same cycle `en_edicion` falls. It stays high until the cycle after `wr_ack` is sampled, then drops together with the return to IDLE.
- Minimum handshake: `wr_ack` in the first WRITE cycle gives a 1-cycle `wr_req`.
- `reset` mid-handshake drops `wr_req` immediately (asynchronously) and restores all reset values.

## Configuration
- `EDITOR_DIAS_MES_EN` defined: day range is month-aware.
  - 30 days for months 04, 06, 09, 11.
  - February: 29 days if the BCD year value is divisible by 4, else 28.
  - 31 days otherwise.
  - When month or year is stepped, `dato_dia` is clamped to the new maximum on the same edge.
- Undefined: day range is fixed at 01–31 and no clamping is done.

## Test plan
- Reset, then `carga` with hour 8'h23, minute 8'h59, second 8'h58 and `f1`=1. `editar`, `sube` on position 0 → hour 8'h00; `baja` → 8'h23; `der` ×2, `sube` → second 8'h59, then 8'h00.
- `f2`=1 only, `editar`. `izq` → `posicion` 2; `baja` on year 8'h00 → 8'h99. `der` ×2 → month; `sube` from 8'h12 → 8'h01.
- `guardar` with `wr_ack` held low 5 cycles then high 1 cycle → `wr_req` high exactly 6 cycles. `sube` pulses during WRITE leave registers unchanged. FSM ends in IDLE.
- Assert `reset` while `wr_req`=1 → all outputs at reset values immediately, no further request.
- With `EDITOR_DIAS_MES_EN`: day 8'h31, month 8'h01, `sube` month → month 8'h02, day 8'h28 (year 8'h23) or 8'h29 (year 8'h24). Without the macro: day stays 8'h31.
- `editar` and `carga` in the same cycle → EDIT entered, registers unchanged. `sube` and `baja` together → no change.
